// File: rtl/speicher_pkg.sv
// speicher_pkg: shared types and constants for the memory-side responder.
// State encoding is one-hot; the request-kind enum also fixes the
// Store > Load > Fetch priority used when several requests arrive together.
package speicher_pkg;

    localparam logic [4:0] Z_IDLE         = 5'b00001;
    localparam logic [4:0] Z_LESEN_BEFEHL = 5'b00010;
    localparam logic [4:0] Z_LESEN_DATEN  = 5'b00100;
    localparam logic [4:0] Z_SCHREIBEN    = 5'b01000;
    localparam logic [4:0] Z_FERTIG       = 5'b10000;

    typedef enum logic [4:0] {
        IDLE         = Z_IDLE,
        LESEN_BEFEHL = Z_LESEN_BEFEHL,
        LESEN_DATEN  = Z_LESEN_DATEN,
        SCHREIBEN    = Z_SCHREIBEN,
        FERTIG       = Z_FERTIG
    } zustand_t;

    localparam int WARTEZYKLEN_STANDARD = 2;

    // Higher encoding wins when requests collide
    typedef enum logic [1:0] {
        ANF_KEINE     = 2'd0,
        ANF_BEFEHL    = 2'd1,
        ANF_LADEN     = 2'd2,
        ANF_SPEICHERN = 2'd3
    } anfrage_t;

    function automatic anfrage_t waehleAnfrage(input logic speichern,
                                               input logic ladenDaten,
                                               input logic holen);
        if (speichern)       return ANF_SPEICHERN;
        else if (ladenDaten) return ANF_LADEN;
        else if (holen)      return ANF_BEFEHL;
        else                 return ANF_KEINE;
    endfunction

endpackage

// File: rtl/speicher_schnittstelle_wartezaehler.sv
// wartezaehler: loadable 4-bit down-counter that stops at zero and
// flags when it is there. Loaded at access start, counts wait states.
module wartezaehler (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       laden,
    input  logic [3:0] wert,
    output logic       istNull
);

    logic [3:0] zaehler;

    // Load on request acceptance, otherwise count down and park at zero
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zaehler <= 4'd0;
        end else if (laden) begin
            zaehler <= wert;
        end else if (zaehler != 4'd0) begin
            zaehler <= zaehler - 4'd1;
        end
    end

    assign istNull = (zaehler == 4'd0);

endmodule

// File: rtl/speicher_schnittstelle.sv
// speicher_schnittstelle: serves fetch/load/store handshakes of the core
// one at a time on a single-port synchronous memory bus with WARTEZYKLEN
// wait states. Optional feature macro SPEICHER_BEREIT_EN adds the MemBereit
// input, which stretches an access until the memory signals ready.
module speicher_schnittstelle
    import speicher_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WARTEZYKLEN = WARTEZYKLEN_STANDARD
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  LoadBefehlSignal,
    input  logic                  LoadDatenSignal,
    input  logic                  StoreDatenSignal,
    input  logic [ADDR_WIDTH-1:0] BefehlAdresse,
    input  logic [ADDR_WIDTH-1:0] DatenAdresse,
    input  logic [DATA_WIDTH-1:0] SchreibDaten,
    output logic [DATA_WIDTH-1:0] Befehl,
    output logic [DATA_WIDTH-1:0] LeseDaten,
    output logic                  BefehlGeladen,
    output logic                  DatenGeladen,
    output logic                  DatenGespeichert,
    output logic [ADDR_WIDTH-1:0] MemAdresse,
    output logic [DATA_WIDTH-1:0] MemSchreibDaten,
    output logic                  MemLesen,
    output logic                  MemSchreiben,
`ifdef SPEICHER_BEREIT_EN
    input  logic                  MemBereit,
`endif
    input  logic [DATA_WIDTH-1:0] MemLeseDaten
);

    zustand_t zustand;
    zustand_t zustandNaechster;
    anfrage_t anfrage;
    logic     annehmen;
    logic     istNull;
    logic     bereit;
    logic     zugriffFertig;

`ifdef SPEICHER_BEREIT_EN
    assign bereit = MemBereit;
`else
    assign bereit = 1'b1;
`endif

    assign anfrage       = waehleAnfrage(StoreDatenSignal, LoadDatenSignal, LoadBefehlSignal);
    assign annehmen      = (zustand == IDLE) && (anfrage != ANF_KEINE);
    assign zugriffFertig = istNull && bereit;

    wartezaehler uWartezaehler (
        .Clock   (Clock),
        .Reset   (Reset),
        .laden   (annehmen),
        .wert    (4'(WARTEZYKLEN)),
        .istNull (istNull)
    );

    // State register; reset parks the controller in IDLE (drops strobes at once)
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            zustand <= IDLE;
        end else begin
            zustand <= zustandNaechster;
        end
    end

    // Next-state: accept one request in IDLE, finish access when wait count expires
    always_comb begin
        zustandNaechster = zustand;
        case (zustand)
            IDLE: begin
                case (anfrage)
                    ANF_SPEICHERN: zustandNaechster = SCHREIBEN;
                    ANF_LADEN:     zustandNaechster = LESEN_DATEN;
                    ANF_BEFEHL:    zustandNaechster = LESEN_BEFEHL;
                    default:       zustandNaechster = IDLE;
                endcase
            end
            LESEN_BEFEHL, LESEN_DATEN, SCHREIBEN: begin
                if (zugriffFertig) begin
                    zustandNaechster = FERTIG;
                end
            end
            FERTIG:  zustandNaechster = IDLE;
            default: zustandNaechster = IDLE;
        endcase
    end

    // Bus address and write data are latched on acceptance and held for the access
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            MemAdresse      <= '0;
            MemSchreibDaten <= '0;
        end else if (annehmen) begin
            MemAdresse <= (anfrage == ANF_BEFEHL) ? BefehlAdresse : DatenAdresse;
            if (anfrage == ANF_SPEICHERN) begin
                MemSchreibDaten <= SchreibDaten;
            end
        end
    end

    // Completion edge: capture read data and raise exactly one done pulse for FERTIG
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Befehl           <= '0;
            LeseDaten        <= '0;
            BefehlGeladen    <= 1'b0;
            DatenGeladen     <= 1'b0;
            DatenGespeichert <= 1'b0;
        end else begin
            BefehlGeladen    <= 1'b0;
            DatenGeladen     <= 1'b0;
            DatenGespeichert <= 1'b0;
            if (zugriffFertig) begin
                case (zustand)
                    LESEN_BEFEHL: begin
                        Befehl        <= MemLeseDaten;
                        BefehlGeladen <= 1'b1;
                    end
                    LESEN_DATEN: begin
                        LeseDaten    <= MemLeseDaten;
                        DatenGeladen <= 1'b1;
                    end
                    SCHREIBEN: begin
                        DatenGespeichert <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign MemLesen     = (zustand == LESEN_BEFEHL) || (zustand == LESEN_DATEN);
    assign MemSchreiben = (zustand == SCHREIBEN);

endmodule

// File: tb/tb_speicher_schnittstelle.sv
// tb_speicher_schnittstelle: scoreboard bench for the memory responder.
// Instance dut uses WARTEZYKLEN=2, instance dut0 uses WARTEZYKLEN=0.
module tb_speicher_schnittstelle;

    localparam logic [2:0] ART_BEFEHL    = 3'b001;
    localparam logic [2:0] ART_LADEN     = 3'b010;
    localparam logic [2:0] ART_SPEICHERN = 3'b100;

    typedef struct packed {
        logic [2:0]  art;
        logic [31:0] daten;
    } erwartung_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        LoadBefehlSignal, LoadDatenSignal, StoreDatenSignal;
    logic [31:0] BefehlAdresse, DatenAdresse, SchreibDaten;
    logic [31:0] Befehl, LeseDaten, MemAdresse, MemSchreibDaten, MemLeseDaten;
    logic        BefehlGeladen, DatenGeladen, DatenGespeichert, MemLesen, MemSchreiben;
`ifdef SPEICHER_BEREIT_EN
    logic        MemBereit;
`endif

    logic        b2LoadDaten;
    logic [31:0] b2DatenAdresse;
    logic [31:0] b2Befehl, b2LeseDaten, b2MemAdresse, b2MemSchreibDaten, b2MemLeseDaten;
    logic        b2BefehlGeladen, b2DatenGeladen, b2DatenGespeichert, b2MemLesen, b2MemSchreiben;

    logic [31:0] mem [0:255];
    erwartung_t  sb [$];
    erwartung_t  sbErw;
    logic [2:0]  sbArt;
    logic [31:0] sbDaten;
    int          tests = 0;
    int          fails = 0;

    assign MemLeseDaten   = mem[MemAdresse[7:0]];
    assign b2MemLeseDaten = mem[b2MemAdresse[7:0]];

    always #5 Clock = ~Clock;

    speicher_schnittstelle #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WARTEZYKLEN(2)) dut (
        .Clock(Clock), .Reset(Reset),
        .LoadBefehlSignal(LoadBefehlSignal), .LoadDatenSignal(LoadDatenSignal),
        .StoreDatenSignal(StoreDatenSignal), .BefehlAdresse(BefehlAdresse),
        .DatenAdresse(DatenAdresse), .SchreibDaten(SchreibDaten),
        .Befehl(Befehl), .LeseDaten(LeseDaten), .BefehlGeladen(BefehlGeladen),
        .DatenGeladen(DatenGeladen), .DatenGespeichert(DatenGespeichert),
        .MemAdresse(MemAdresse), .MemSchreibDaten(MemSchreibDaten),
        .MemLesen(MemLesen), .MemSchreiben(MemSchreiben),
`ifdef SPEICHER_BEREIT_EN
        .MemBereit(MemBereit),
`endif
        .MemLeseDaten(MemLeseDaten)
    );

    speicher_schnittstelle #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WARTEZYKLEN(0)) dut0 (
        .Clock(Clock), .Reset(Reset),
        .LoadBefehlSignal(1'b0), .LoadDatenSignal(b2LoadDaten),
        .StoreDatenSignal(1'b0), .BefehlAdresse(32'h0),
        .DatenAdresse(b2DatenAdresse), .SchreibDaten(32'h0),
        .Befehl(b2Befehl), .LeseDaten(b2LeseDaten), .BefehlGeladen(b2BefehlGeladen),
        .DatenGeladen(b2DatenGeladen), .DatenGespeichert(b2DatenGespeichert),
        .MemAdresse(b2MemAdresse), .MemSchreibDaten(b2MemSchreibDaten),
        .MemLesen(b2MemLesen), .MemSchreiben(b2MemSchreiben),
`ifdef SPEICHER_BEREIT_EN
        .MemBereit(1'b1),
`endif
        .MemLeseDaten(b2MemLeseDaten)
    );

    task automatic takt;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) takt();
        tests++;
        if ({Befehl, LeseDaten, MemAdresse, MemSchreibDaten, BefehlGeladen, DatenGeladen,
             DatenGespeichert, MemLesen, MemSchreiben} !== '0) begin
            fails++;
            $display("FAIL reset_ausgaenge: Befehl=%h LeseDaten=%h MemAdresse=%h MemSchreibDaten=%h pulse=%b%b%b strobes=%b%b, required all 0",
                     Befehl, LeseDaten, MemAdresse, MemSchreibDaten, BefehlGeladen, DatenGeladen,
                     DatenGespeichert, MemLesen, MemSchreiben);
        end
        Reset = 1'b0;
        takt();
        tests++;
        if ({MemLesen, MemSchreiben, BefehlGeladen, DatenGeladen, DatenGespeichert} !== 5'b0) begin
            fails++;
            $display("FAIL reset_idle: strobes/pulses=%b, required 00000",
                     {MemLesen, MemSchreiben, BefehlGeladen, DatenGeladen, DatenGespeichert});
        end
    endtask

    task automatic test_fetch;
        BefehlAdresse    = 32'h40;
        LoadBefehlSignal = 1'b1;
        sb.push_back({ART_BEFEHL, 32'hDEADBEEF});
        for (int c = 1; c <= 6; c++) begin
            takt();
            tests++;
            if (MemLesen !== (c <= 3) || MemSchreiben !== 1'b0 || (c <= 3 && MemAdresse !== 32'h40) ||
                BefehlGeladen !== (c == 4) || (c >= 4 && Befehl !== 32'hDEADBEEF)) begin
                fails++;
                $display("FAIL fetch_zyklus%0d: MemLesen=%b MemAdresse=%h BefehlGeladen=%b Befehl=%h, required MemLesen=%b Adresse=40 BefehlGeladen=%b Befehl=deadbeef",
                         c, MemLesen, MemAdresse, BefehlGeladen, Befehl, (c <= 3), (c == 4));
            end
            if (c == 4) LoadBefehlSignal = 1'b0;
        end
    endtask

    task automatic test_load;
        DatenAdresse    = 32'h20;
        LoadDatenSignal = 1'b1;
        sb.push_back({ART_LADEN, 32'h0BADF00D});
        for (int c = 1; c <= 5; c++) begin
            takt();
            tests++;
            if (MemLesen !== (c <= 3) || (c <= 3 && MemAdresse !== 32'h20) ||
                DatenGeladen !== (c == 4) || (c >= 4 && LeseDaten !== 32'h0BADF00D)) begin
                fails++;
                $display("FAIL load_zyklus%0d: MemLesen=%b MemAdresse=%h DatenGeladen=%b LeseDaten=%h, required MemLesen=%b Adresse=20 DatenGeladen=%b LeseDaten=0badf00d",
                         c, MemLesen, MemAdresse, DatenGeladen, LeseDaten, (c <= 3), (c == 4));
            end
            if (c == 4) LoadDatenSignal = 1'b0;
        end
        tests++;
        if (Befehl !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL load_befehl_unveraendert: Befehl=%h, required deadbeef", Befehl);
        end
    endtask

    task automatic test_store;
        int pulse = 0;
        DatenAdresse     = 32'h10;
        SchreibDaten     = 32'h12345678;
        StoreDatenSignal = 1'b1;
        sb.push_back({ART_SPEICHERN, 32'h0});
        for (int c = 1; c <= 6; c++) begin
            takt();
            if (c == 1) begin
                DatenAdresse = 32'h99;
                SchreibDaten = 32'h0;
            end
            pulse += int'(DatenGespeichert);
            tests++;
            if (MemSchreiben !== (c <= 3) || MemLesen !== 1'b0 ||
                (c <= 3 && {MemAdresse, MemSchreibDaten} !== {32'h10, 32'h12345678}) ||
                DatenGespeichert !== (c == 4)) begin
                fails++;
                $display("FAIL store_zyklus%0d: MemSchreiben=%b MemLesen=%b MemAdresse=%h MemSchreibDaten=%h DatenGespeichert=%b, required MemSchreiben=%b Adresse=10 Daten=12345678 DatenGespeichert=%b",
                         c, MemSchreiben, MemLesen, MemAdresse, MemSchreibDaten, DatenGespeichert, (c <= 3), (c == 4));
            end
            if (c == 4) StoreDatenSignal = 1'b0;
        end
        tests++;
        if (pulse != 1 || mem[8'h10] !== 32'h12345678 || LeseDaten !== 32'h0BADF00D || Befehl !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL store_ergebnis: pulses=%0d mem[10]=%h LeseDaten=%h Befehl=%h, required 1 12345678 0badf00d deadbeef",
                     pulse, mem[8'h10], LeseDaten, Befehl);
        end
    endtask

    task automatic test_priority;
        DatenAdresse     = 32'h11;
        SchreibDaten     = 32'hCAFEF00D;
        BefehlAdresse    = 32'h44;
        StoreDatenSignal = 1'b1;
        LoadBefehlSignal = 1'b1;
        sb.push_back({ART_SPEICHERN, 32'h0});
        sb.push_back({ART_BEFEHL, 32'hA5C3E144});
        for (int c = 1; c <= 10; c++) begin
            takt();
            if (c == 1 || c == 4 || c == 5 || c == 6 || c == 9) begin
                tests++;
                if ((c == 1 && {MemSchreiben, MemLesen, MemAdresse} !== {2'b10, 32'h11}) ||
                    (c == 4 && {DatenGespeichert, BefehlGeladen} !== 2'b10) ||
                    (c == 5 && {MemSchreiben, MemLesen} !== 2'b00) ||
                    (c == 6 && {MemSchreiben, MemLesen, MemAdresse} !== {2'b01, 32'h44}) ||
                    (c == 9 && {BefehlGeladen, Befehl} !== {1'b1, 32'hA5C3E144})) begin
                    fails++;
                    $display("FAIL prio_store_fetch_zyklus%0d: MemSchreiben=%b MemLesen=%b MemAdresse=%h DatenGespeichert=%b BefehlGeladen=%b Befehl=%h, required store first then fetch of 44 (a5c3e144)",
                             c, MemSchreiben, MemLesen, MemAdresse, DatenGespeichert, BefehlGeladen, Befehl);
                end
            end
            if (DatenGespeichert) StoreDatenSignal = 1'b0;
            if (BefehlGeladen) LoadBefehlSignal = 1'b0;
        end
        DatenAdresse     = 32'h22;
        BefehlAdresse    = 32'h48;
        LoadDatenSignal  = 1'b1;
        LoadBefehlSignal = 1'b1;
        sb.push_back({ART_LADEN, 32'hA5C3E122});
        sb.push_back({ART_BEFEHL, 32'hA5C3E148});
        for (int c = 1; c <= 12; c++) begin
            takt();
            if (c == 1) begin
                tests++;
                if ({MemLesen, MemAdresse} !== {1'b1, 32'h22}) begin
                    fails++;
                    $display("FAIL prio_load_fetch: MemLesen=%b MemAdresse=%h, required 1 00000022", MemLesen, MemAdresse);
                end
            end
            if (DatenGeladen) LoadDatenSignal = 1'b0;
            if (BefehlGeladen) LoadBefehlSignal = 1'b0;
        end
        tests++;
        if ({LoadDatenSignal, LoadBefehlSignal} !== 2'b00) begin
            fails++;
            $display("FAIL prio_load_fetch_fertig: requests still open=%b, required 00", {LoadDatenSignal, LoadBefehlSignal});
        end
    endtask

    task automatic test_reset_abort;
        int pulse = 0;
        DatenAdresse    = 32'h30;
        LoadDatenSignal = 1'b1;
        takt();
        takt();
        tests++;
        if (MemLesen !== 1'b1) begin
            fails++;
            $display("FAIL abort_vor_reset: MemLesen=%b, required 1", MemLesen);
        end
        #2 Reset = 1'b1;
        #1;
        tests++;
        if ({MemLesen, MemSchreiben, MemAdresse} !== '0) begin
            fails++;
            $display("FAIL abort_strobes_async: MemLesen=%b MemSchreiben=%b MemAdresse=%h, required 0 0 0",
                     MemLesen, MemSchreiben, MemAdresse);
        end
        LoadDatenSignal = 1'b0;
        for (int c = 0; c < 8; c++) begin
            takt();
            if (c == 1) Reset = 1'b0;
            pulse += int'(DatenGeladen) + int'(MemLesen);
        end
        tests++;
        if (pulse != 0) begin
            fails++;
            $display("FAIL abort_kein_puls: pulse/strobe cycles=%0d, required 0", pulse);
        end
        LoadDatenSignal = 1'b1;
        sb.push_back({ART_LADEN, 32'hA5C3E130});
        for (int c = 1; c <= 5; c++) begin
            takt();
            tests++;
            if (MemLesen !== (c <= 3) || DatenGeladen !== (c == 4) || (c >= 4 && LeseDaten !== 32'hA5C3E130)) begin
                fails++;
                $display("FAIL abort_neuer_load_zyklus%0d: MemLesen=%b DatenGeladen=%b LeseDaten=%h, required %b %b a5c3e130",
                         c, MemLesen, DatenGeladen, LeseDaten, (c <= 3), (c == 4));
            end
            if (c == 4) LoadDatenSignal = 1'b0;
        end
    endtask

`ifdef SPEICHER_BEREIT_EN
    task automatic test_bereit;
        MemBereit       = 1'b0;
        DatenAdresse    = 32'h24;
        LoadDatenSignal = 1'b1;
        sb.push_back({ART_LADEN, 32'hA5C3E124});
        for (int c = 1; c <= 10; c++) begin
            takt();
            tests++;
            if (MemLesen !== (c <= 8) || (c <= 8 && MemAdresse !== 32'h24) || DatenGeladen !== (c == 9)) begin
                fails++;
                $display("FAIL bereit_zyklus%0d: MemLesen=%b MemAdresse=%h DatenGeladen=%b, required %b 24 %b",
                         c, MemLesen, MemAdresse, DatenGeladen, (c <= 8), (c == 9));
            end
            if (c == 8) MemBereit = 1'b1;
            if (c == 9) LoadDatenSignal = 1'b0;
        end
    endtask
`endif

    task automatic test_back_to_back;
        int pulse = 0;
        b2DatenAdresse = 32'h50;
        b2LoadDaten    = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            takt();
            pulse += int'(b2DatenGeladen);
            tests++;
            if (b2MemLesen !== (c % 3 == 1) || b2DatenGeladen !== (c % 3 == 2) ||
                (c % 3 == 2 && b2LeseDaten !== 32'hA5C3E150)) begin
                fails++;
                $display("FAIL b2b_zyklus%0d: MemLesen=%b DatenGeladen=%b LeseDaten=%h, required %b %b a5c3e150",
                         c, b2MemLesen, b2DatenGeladen, b2LeseDaten, (c % 3 == 1), (c % 3 == 2));
            end
        end
        b2LoadDaten = 1'b0;
        tests++;
        if (pulse != 4 || {b2Befehl, b2MemSchreibDaten, b2BefehlGeladen, b2DatenGespeichert, b2MemSchreiben} !== '0) begin
            fails++;
            $display("FAIL b2b_summe: pulses=%0d Befehl=%h MemSchreibDaten=%h other=%b, required 4 0 0 000",
                     pulse, b2Befehl, b2MemSchreibDaten, {b2BefehlGeladen, b2DatenGespeichert, b2MemSchreiben});
        end
    endtask

    initial begin
        Reset            = 1'b1;
        LoadBefehlSignal = 1'b0;
        LoadDatenSignal  = 1'b0;
        StoreDatenSignal = 1'b0;
        BefehlAdresse    = 32'h0;
        DatenAdresse     = 32'h0;
        SchreibDaten     = 32'h0;
        b2LoadDaten      = 1'b0;
        b2DatenAdresse   = 32'h0;
`ifdef SPEICHER_BEREIT_EN
        MemBereit        = 1'b1;
`endif
        for (int i = 0; i < 256; i++) mem[i] = {24'hA5C3E1, 8'(i)};
        mem[8'h40] = 32'hDEADBEEF;
        mem[8'h20] = 32'h0BADF00D;

        // Memory write model and scoreboard consumer, sampled mid-cycle
        fork
            forever begin
                @(negedge Clock);
                if (MemSchreiben) mem[MemAdresse[7:0]] = MemSchreibDaten;
                if (BefehlGeladen || DatenGeladen || DatenGespeichert) begin
                    sbArt   = {DatenGespeichert, DatenGeladen, BefehlGeladen};
                    sbDaten = BefehlGeladen ? Befehl : (DatenGeladen ? LeseDaten : 32'h0);
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL sb_unerwartet: pulse=%b data=%h, required no pulse", sbArt, sbDaten);
                    end else begin
                        sbErw = sb.pop_front();
                        if ({sbArt, sbDaten} !== {sbErw.art, sbErw.daten}) begin
                            fails++;
                            $display("FAIL sb_abschluss: pulse=%b data=%h, required pulse=%b data=%h",
                                     sbArt, sbDaten, sbErw.art, sbErw.daten);
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_priority();
        test_reset_abort();
`ifdef SPEICHER_BEREIT_EN
        test_bereit();
`endif
        test_back_to_back();
        repeat (3) takt();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_offen: %0d completions outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/speicher_schnittstelle.md
# speicher_schnittstelle

Memory-side responder for the processor control FSM's fetch/load/store handshakes. Accepts the level-held `LoadBefehlSignal`, `LoadDatenSignal` and `StoreDatenSignal` requests and runs one access at a time on a single-port synchronous SRAM-style bus with a configurable number of wait states. Returns the one-cycle completion pulses `BefehlGeladen`, `DatenGeladen` and `DatenGespeichert`, together with registered read data. Sits between the processor core and the shared instruction/data memory.

## Interface
- `ADDR_WIDTH`, 32, word address width
- `DATA_WIDTH`, 32, data word width
- `WARTEZYKLEN`, 2, wait cycles per access (0..15); bus strobes are held for `WARTEZYKLEN+1` cycles
- `Clock  input  1  system clock, all state updates on rising edge`
- `Reset  input  1  asynchronous, active-high`
- `LoadBefehlSignal  input  1  fetch request, level, held until BefehlGeladen`
- `LoadDatenSignal  input  1  data load request, level`
- `StoreDatenSignal  input  1  data store request, level`
- `BefehlAdresse  input  ADDR_WIDTH  fetch address (PC)`
- `DatenAdresse  input  ADDR_WIDTH  load/store address`
- `SchreibDaten  input  DATA_WIDTH  store data`
- `Befehl  output  DATA_WIDTH  last fetched instruction, registered`
- `LeseDaten  output  DATA_WIDTH  last loaded data word, registered`
- `BefehlGeladen  output  1  one-cycle fetch-done pulse`
- `DatenGeladen  output  1  one-cycle load-done pulse`
- `DatenGespeichert  output  1  one-cycle store-done pulse`
- `MemAdresse  output  ADDR_WIDTH  bus address`
- `MemSchreibDaten  output  DATA_WIDTH  bus write data`
- `MemLeseDaten  input  DATA_WIDTH  bus read data`
- `MemLesen  output  1  bus read strobe`
- `MemSchreiben  output  1  bus write strobe`
- `MemBereit  input  1  bus ready; present only with SPEICHER_BEREIT_EN`

## Operation
- States: IDLE, LESEN_BEFEHL, LESEN_DATEN, SCHREIBEN, FERTIG.
- IDLE: if any request is high at a rising edge, latch the address (and `SchreibDaten` for stores) into bus registers and load the wait counter with `WARTEZYKLEN`.
  - Priority for simultaneous requests: Store > Load > Fetch.
  - Only one request is accepted per pass through IDLE.
- Access states: `MemLesen` (LESEN_*) or `MemSchreiben` (SCHREIBEN) is high and driven from the state register; address and write data are held stable.
  - Counter decrements each cycle.
  - When counter = 0 (and `MemBereit`=1 if enabled): at that edge, capture `MemLeseDaten` into `Befehl` or `LeseDaten`, set the matching done register, and go to FERTIG.
- FERTIG: exactly one done output is high, strobes are low; unconditionally go to IDLE.
  - The controller drops its request in the cycle after the pulse, so no re-trigger occurs.
- A request dropped mid-access does not abort it: the access completes and the pulse is still issued.
- Requests are ignored outside IDLE.
- Read-data registers hold their value until the next completion of the same kind.
- Stores do not modify `Befehl` or `LeseDaten`.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. Strobes drop asynchronously on `Reset`.
- Reset mid-access abandons the access. No done pulse is issued; no data is captured.
- Latency: request high in cycle 0 → strobes in cycles 1..`WARTEZYKLEN+1` → done pulse in cycle `WARTEZYKLEN+2`. With `WARTEZYKLEN`=0, done arrives in cycle 2.
- Back-to-back: the earliest next acceptance is the cycle after FERTIG (IDLE). Minimum period is `WARTEZYKLEN+3` cycles.
- Done outputs and read data are registered. No combinational path exists from request inputs to any output.

## Configuration
- `SPEICHER_BEREIT_EN` defined:
  - `MemBereit` port exists.
  - After the counter reaches 0, the access state is held (strobes and address stable, counter at 0) until `MemBereit`=1.
  - Data is captured on the edge where `MemBereit`=1.
- Not defined: no `MemBereit` port; access length is fixed at `WARTEZYKLEN+1` cycles.

## Structure
- Package `speicher_pkg`:
  - state encoding localparams (one-hot, 5 bits)
  - default `WARTEZYKLEN`
  - request-priority constants
- Sub-module `wartezaehler`: loadable 4-bit down-counter with `laden`, `wert` and `null` flag, instantiated once.

## Test plan
- Fetch, `WARTEZYKLEN`=2, `BefehlAdresse`=0x40, memory[0x40]=0xDEADBEEF:
  - `MemLesen` high cycles 1–3 with `MemAdresse`=0x40
  - `BefehlGeladen` pulse in cycle 4
  - `Befehl`=0xDEADBEEF from cycle 4 on
- Store 0x12345678 to 0x10:
  - `MemSchreiben` high 3 cycles with stable address/data
  - single `DatenGespeichert` pulse
  - `LeseDaten` unchanged
- Store and fetch raised in the same cycle:
  - store is served first
  - fetch is accepted the cycle after FERTIG
  - two separate pulses, store then fetch
- Reset asserted in cycle 2 of a load:
  - strobes 0 immediately, no `DatenGeladen` pulse
  - after release, a new load completes normally
- `SPEICHER_BEREIT_EN`, `MemBereit` low for 5 extra cycles:
  - `MemLesen` held for 3+5 cycles
  - `DatenGeladen` pulses one cycle after `MemBereit` rises
- `WARTEZYKLEN`=0, load request held continuously:
  - one access per 3 cycles
  - each completion gives exactly one one-cycle pulse
